// File: rtl/pipe_dbg_pkg.sv
// Purpose: shared types and defaults for the pipe_top run/debug sequencer.
package pipe_dbg_pkg;

  // Run/debug sequencer states
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    DRAIN    = 3'd1,
    HALTED   = 3'd2,
    STEP     = 3'd3,
    DUMP_RD  = 3'd4,
    DUMP_CAP = 3'd5
  } run_state_e;

  // Default drain budget: pipeline depth in cycles
  localparam int unsigned DRAIN_CYC_DEF = 5;

endpackage : pipe_dbg_pkg

// File: rtl/rise_det.sv
// Purpose: registered 1-bit rising-edge detector with synchronous reset.
// Ports:
//   i_clk    - clock
//   i_rst    - synchronous active-high reset (clears the history bit)
//   i_d      - level input
//   o_rise_c - combinational: i_d high now and low on the previous edge
module rise_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise_c
);

  logic r_q;

  // Previous-cycle copy of the input
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise_c = i_d & ~r_q;

endmodule : rise_det

// File: rtl/pipe_run_ctrl.sv
// Purpose: run/debug sequencer for pipe_top. Gates fetch on stop, PC breakpoint
//   or single step, drains the pipeline before declaring halt, and while halted
//   reads the data-memory word selected by i_pos into o_show.
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_stop              - level halt request
//   i_step              - debounced step button (rising edge = one step)
//   i_bp_en, i_bp_pc    - breakpoint enable and fetch address
//   i_pc                - core fetch PC
//   i_pipe_busy         - any pipeline stage holds a valid instruction
//   i_pos               - data-memory word index to inspect
//   i_dmem_rdata        - debug read data, one cycle after the strobe
//   o_fetch_en          - IF may fetch / advance pc
//   o_core_stall        - freeze all pipeline registers
//   o_dmem_dbg_re       - debug read strobe
//   o_dmem_dbg_addr     - debug read address (always i_pos)
//   o_show              - last captured memory word
//   o_halted            - core frozen and drained
//   o_bp_hit            - sticky breakpoint flag
//   o_cycle_cnt         - saturating count of fetch-enabled cycles
module pipe_run_ctrl
  import pipe_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned POS_W     = 6,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stop,
  input  logic              i_step,
  input  logic              i_bp_en,
  input  logic [ADDR_W-1:0] i_bp_pc,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pipe_busy,
  input  logic [POS_W-1:0]  i_pos,
  input  logic [ADDR_W-1:0] i_dmem_rdata,
  output logic              o_fetch_en,
  output logic              o_core_stall,
  output logic              o_dmem_dbg_re,
  output logic [POS_W-1:0]  o_dmem_dbg_addr,
  output logic [ADDR_W-1:0] o_show,
  output logic              o_halted,
  output logic              o_bp_hit,
  output logic [ADDR_W-1:0] o_cycle_cnt
);

  localparam int unsigned DCNT_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYC - 1);

  run_state_e        r_state;
  logic [DCNT_W-1:0] r_drain_cnt;
  logic              r_bp_hit;
  logic              r_bp_armed;
  logic [POS_W-1:0]  r_pos_q;
  logic [ADDR_W-1:0] r_show;
  logic [ADDR_W-1:0] r_cycle_cnt;

  run_state_e        w_state_nxt;
  logic [DCNT_W-1:0] w_drain_nxt;
  logic              w_bp_hit_nxt;
  logic              w_arm_clr;
  logic              w_arm_nxt;
  logic [POS_W-1:0]  w_pos_q_nxt;
  logic [ADDR_W-1:0] w_show_nxt;
  logic              w_step_re;
  logic              w_bp_m;
  logic              w_fetch_en;

  rise_det u_step_det (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_d      (i_step),
    .o_rise_c (w_step_re)
  );

  assign w_bp_m = i_bp_en & r_bp_armed & (i_pc == i_bp_pc);

  // Sequencer state register and its side registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_bp_hit    <= 1'b0;
      r_bp_armed  <= 1'b1;
      r_pos_q     <= '0;
      r_show      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_bp_hit    <= w_bp_hit_nxt;
      r_bp_armed  <= w_arm_nxt;
      r_pos_q     <= w_pos_q_nxt;
      r_show      <= w_show_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_drain_nxt  = r_drain_cnt;
    w_bp_hit_nxt = r_bp_hit;
    w_arm_clr    = 1'b0;
    w_pos_q_nxt  = r_pos_q;
    w_show_nxt   = r_show;
    unique case (r_state)
      RUN: begin
        if (i_stop | w_bp_m) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = '0;
          if (w_bp_m) begin
            w_bp_hit_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Leave early once the pipe is empty; otherwise give up after the budget
        if (!i_pipe_busy || (r_drain_cnt == DCNT_LAST)) begin
          w_state_nxt = DUMP_RD;
        end else begin
          w_drain_nxt = r_drain_cnt + DCNT_W'(1);
        end
      end
      DUMP_RD: begin
        w_pos_q_nxt = i_pos;
        w_state_nxt = DUMP_CAP;
      end
      DUMP_CAP: begin
        w_show_nxt  = i_dmem_rdata;
        w_state_nxt = HALTED;
      end
      HALTED: begin
        // Step outranks a pending inspect; the inspect is served by the post-step dump
        if (w_step_re) begin
          w_state_nxt  = STEP;
          w_bp_hit_nxt = 1'b0;
          w_arm_clr    = 1'b1;
        end else if (i_pos != r_pos_q) begin
          w_state_nxt = DUMP_RD;
        end else if (!i_stop && !r_bp_hit) begin
          w_state_nxt = RUN;
          w_arm_clr   = 1'b1;
        end
      end
      STEP: begin
        w_state_nxt = DRAIN;
        w_drain_nxt = '0;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Breakpoint re-arms as soon as the PC moves off the breakpoint address
  always_comb begin
    w_arm_nxt = r_bp_armed;
    if (i_pc != i_bp_pc) begin
      w_arm_nxt = 1'b1;
    end else if (w_arm_clr) begin
      w_arm_nxt = 1'b0;
    end
  end

  // Output decode from state
  always_comb begin
    w_fetch_en    = 1'b0;
    o_core_stall  = 1'b0;
    o_halted      = 1'b0;
    o_dmem_dbg_re = 1'b0;
    unique case (r_state)
      RUN, STEP: begin
        w_fetch_en = 1'b1;
      end
      HALTED, DUMP_CAP: begin
        o_core_stall = 1'b1;
        o_halted     = 1'b1;
      end
      DUMP_RD: begin
        o_core_stall  = 1'b1;
        o_halted      = 1'b1;
        o_dmem_dbg_re = 1'b1;
      end
      default: begin
        w_fetch_en = 1'b0;
      end
    endcase
  end

  // Saturating fetch-cycle counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_cnt <= '0;
    end else if (w_fetch_en && (r_cycle_cnt != {ADDR_W{1'b1}})) begin
      r_cycle_cnt <= r_cycle_cnt + ADDR_W'(1);
    end
  end

  assign o_fetch_en      = w_fetch_en;
  assign o_dmem_dbg_addr = i_pos;
  assign o_show          = r_show;
  assign o_bp_hit        = r_bp_hit;
  assign o_cycle_cnt     = r_cycle_cnt;

endmodule : pipe_run_ctrl

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: directed stimulus, debug reads checked by a scoreboard.
module tb_pipe_run_ctrl;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk;
  logic        rst;
  logic        stop;
  logic        step;
  logic        bp_en;
  logic [31:0] bp_pc;
  logic [31:0] pc;
  logic        pipe_busy;
  logic [5:0]  pos;
  logic [31:0] dmem_rdata;
  logic        fetch_en;
  logic        core_stall;
  logic        dmem_dbg_re;
  logic [5:0]  dmem_dbg_addr;
  logic [31:0] show;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycle_cnt;

  // narrow instance so counter saturation is reachable quickly
  logic        s_rst;
  logic        s_fetch_en;
  logic        s_core_stall;
  logic        s_re;
  logic [5:0]  s_addr;
  logic [3:0]  s_show;
  logic        s_halted;
  logic        s_bp_hit;
  logic [3:0]  s_cycle_cnt;

  logic        pc_hold;
  rd_exp_t     exp_q[$];
  int          n_checks;
  int          n_errors;
  int          fcyc;

  pipe_run_ctrl #(.ADDR_W(32), .POS_W(6), .DRAIN_CYC(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_stop(stop), .i_step(step), .i_bp_en(bp_en),
    .i_bp_pc(bp_pc), .i_pc(pc), .i_pipe_busy(pipe_busy), .i_pos(pos),
    .i_dmem_rdata(dmem_rdata), .o_fetch_en(fetch_en), .o_core_stall(core_stall),
    .o_dmem_dbg_re(dmem_dbg_re), .o_dmem_dbg_addr(dmem_dbg_addr), .o_show(show),
    .o_halted(halted), .o_bp_hit(bp_hit), .o_cycle_cnt(cycle_cnt)
  );

  pipe_run_ctrl #(.ADDR_W(4), .POS_W(6), .DRAIN_CYC(5)) dut_sat (
    .i_clk(clk), .i_rst(s_rst), .i_stop(1'b0), .i_step(1'b0), .i_bp_en(1'b0),
    .i_bp_pc(4'h0), .i_pc(4'h1), .i_pipe_busy(1'b0), .i_pos(6'h00),
    .i_dmem_rdata(4'h0), .o_fetch_en(s_fetch_en), .o_core_stall(s_core_stall),
    .o_dmem_dbg_re(s_re), .o_dmem_dbg_addr(s_addr), .o_show(s_show),
    .o_halted(s_halted), .o_bp_hit(s_bp_hit), .o_cycle_cnt(s_cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_lut(input logic [5:0] a);
    case (a)
      6'h00:   return 32'hDEAD_BEEF;
      6'h3b:   return 32'h1234_5678;
      6'h05:   return 32'hCAFE_F00D;
      default: return 32'(a);
    endcase
  endfunction

  // Data memory debug port: one-cycle synchronous read
  always @(posedge clk) begin
    if (dmem_dbg_re) dmem_rdata <= mem_lut(dmem_dbg_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] status();
    return {fetch_en, halted, core_stall, dmem_dbg_re};
  endfunction

  // Advance one clock; the core model moves pc when fetch was enabled
  task automatic tick();
    logic fe;
    fe = fetch_en;
    @(posedge clk);
    #1;
    if (fe && !pc_hold) pc = pc + 32'd4;
  endtask

  task automatic wait_halt(input int budget, output int fcycles);
    int n;
    n = 0;
    fcycles = 0;
    while (!halted && n < budget) begin
      if (fetch_en) fcycles++;
      tick();
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; s_rst = 1'b1; stop = 1'b0; step = 1'b0; bp_en = 1'b0;
    bp_pc = 32'h0; pc = 32'h0; pipe_busy = 1'b0; pos = 6'h00;
    dmem_rdata = 32'h0; pc_hold = 1'b0;

    // Scoreboard monitor: every debug read must match the next expected entry
    fork
      forever begin
        rd_exp_t e;
        @(negedge clk);
        if (dmem_dbg_re) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_read: got addr %h expected no read", dmem_dbg_addr);
          end else begin
            e = exp_q.pop_front();
            chk("rd_addr", 32'(dmem_dbg_addr), 32'(e.addr));
            @(negedge clk);
            chk("rd_pulse_len", 32'(dmem_dbg_re), 32'd0);
            @(negedge clk);
            chk("rd_show", show, e.data);
          end
        end
      end
    join_none

    // 1: reset and run
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_status", 32'(status()), 32'(4'b1000));
    chk("rst_show", show, 32'h0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);
    repeat (10) tick();
    chk("run_cnt10", cycle_cnt, 32'd10);

    // 2: stop with a busy pipe, full drain then dump of word 0
    pipe_busy = 1'b1;
    exp_q.push_back('{addr: 6'h00, data: 32'hDEAD_BEEF});
    stop = 1'b1;
    chk("stop_same_cycle", 32'(fetch_en), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_%0d", i), 32'(status()), 32'(4'b0000));
      tick();
    end
    chk("dump_rd_status", 32'(status()), 32'(4'b0111));
    chk("dump_rd_addr", 32'(dmem_dbg_addr), 32'h00);
    tick();
    tick();
    chk("halt_status", 32'(status()), 32'(4'b0110));
    chk("halt_cnt_frozen", cycle_cnt, 32'd11);

    // 3: inspect a different word, then no further reads while pos is steady
    exp_q.push_back('{addr: 6'h3b, data: 32'h1234_5678});
    pos = 6'h3b;
    tick();
    chk("insp_rd_status", 32'(status()), 32'(4'b0111));
    tick();
    tick();
    chk("insp_show", show, 32'h1234_5678);
    repeat (6) tick();
    chk("insp_idle", 32'(status()), 32'(4'b0110));

    // 4: breakpoint at 0x40, single step, resume without re-hit
    pc = 32'h30; bp_pc = 32'h40; bp_en = 1'b1; pipe_busy = 1'b0;
    exp_q.push_back('{addr: 6'h3b, data: 32'h1234_5678});
    stop = 1'b0;
    tick();
    chk("bp_resume_run", 32'(status()), 32'(4'b1000));
    wait_halt(30, fcyc);
    chk("bp_fetch_cycles", 32'(fcyc), 32'd5);
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    chk("bp_pc_after", pc, 32'h44);
    repeat (2) tick();
    chk("bp_stays_halted", 32'(status()), 32'(4'b0110));
    pc = 32'h40; pc_hold = 1'b1; stop = 1'b1;
    exp_q.push_back('{addr: 6'h3b, data: 32'h1234_5678});
    step = 1'b1;
    tick();
    chk("step_status", 32'(status()), 32'(4'b1000));
    chk("step_clears_bp", 32'(bp_hit), 32'd0);
    wait_halt(20, fcyc);
    chk("step_one_fetch", 32'(fcyc), 32'd1);
    step = 1'b0;
    repeat (2) tick();
    chk("step_halted", 32'(status()), 32'(4'b0110));
    stop = 1'b0;
    tick();
    repeat (4) tick();
    chk("no_rehit_status", 32'(status()), 32'(4'b1000));
    chk("no_rehit_flag", 32'(bp_hit), 32'd0);
    pc_hold = 1'b0;
    repeat (3) tick();
    chk("run_on", 32'(status()), 32'(4'b1000));

    // 5a: step edge and pos change together, stop held through the step
    bp_en = 1'b0;
    exp_q.push_back('{addr: 6'h3b, data: 32'h1234_5678});
    stop = 1'b1;
    tick();
    wait_halt(20, fcyc);
    repeat (2) tick();
    exp_q.push_back('{addr: 6'h05, data: 32'hCAFE_F00D});
    step = 1'b1; pos = 6'h05;
    tick();
    chk("coll_step_first", 32'(status()), 32'(4'b1000));
    wait_halt(20, fcyc);
    chk("coll_one_fetch", 32'(fcyc), 32'd1);
    step = 1'b0;
    repeat (5) tick();
    chk("coll_settled", 32'(status()), 32'(4'b0110));
    chk("coll_show", show, 32'hCAFE_F00D);

    // 5c: reset during capture abandons the dump
    exp_q.push_back('{addr: 6'h3b, data: 32'h0});
    pos = 6'h3b;
    tick();
    chk("rstcap_rd", 32'(status()), 32'(4'b0111));
    tick();
    chk("rstcap_cap", 32'(status()), 32'(4'b0110));
    rst = 1'b1;
    tick();
    rst = 1'b0; stop = 1'b0;
    chk("rstcap_status", 32'(status()), 32'(4'b1000));
    chk("rstcap_show", show, 32'h0);
    chk("rstcap_cnt", cycle_cnt, 32'd0);

    // 6: saturation on the narrow instance
    s_rst = 1'b0;
    repeat (14) tick();
    chk("sat_cnt14", 32'(s_cycle_cnt), 32'd14);
    tick();
    chk("sat_cnt15", 32'(s_cycle_cnt), 32'd15);
    repeat (4) tick();
    chk("sat_hold", 32'(s_cycle_cnt), 32'd15);
    chk("sat_fetch", 32'(s_fetch_en), 32'd1);

    repeat (4) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_run_ctrl
